// File: rtl/permute_pipe_pkg.sv
// Shared descriptions for the odd-pipe permute unit.
// Holds the opcode enum, the permute-group decoder and the forwarding tap layout.
package permute_pipe_pkg;

  // Width the odd pipe is normally built at; fw_tap_t is laid out for it.
  localparam int unsigned PERM_WIDTH = 128;

  typedef enum logic [10:0] {
    OpNop      = 11'h201,
    OpA        = 11'h0C0,
    OpAnd      = 11'h0C1,
    OpShlqbi   = 11'h1DB,
    OpShlqbii  = 11'h1FB,
    OpShlqby   = 11'h1DF,
    OpShlqbyi  = 11'h1FF,
    OpShlqbybi = 11'h1CF,
    OpRotqby   = 11'h1DC,
    OpRotqbyi  = 11'h1FC,
    OpRotqbybi = 11'h1CC,
    OpRotqbi   = 11'h1D8,
    OpRotqbii  = 11'h1F8,
    OpGbb      = 11'h1B2,
    OpGbh      = 11'h1B1,
    OpGb       = 11'h1B0
  } opcode_t;

  // Forwarding tap: {valid, rt_address, data}, most significant field first.
  typedef struct packed {
    logic                  valid;
    logic [6:0]            rt_address;
    logic [PERM_WIDTH-1:0] data;
  } fw_tap_t;

  localparam int unsigned FW_TAP_BITS = $bits(fw_tap_t);

  // Tap size for an arbitrary data width (same valid + address overhead).
  function automatic int unsigned fw_tap_bits(input int unsigned width);
    return width + FW_TAP_BITS - PERM_WIDTH;
  endfunction

  function automatic logic is_permute_op(input opcode_t op);
    case (op)
      OpShlqbi, OpShlqbii, OpShlqby, OpShlqbyi, OpShlqbybi,
      OpRotqby, OpRotqbyi, OpRotqbybi, OpRotqbi, OpRotqbii,
      OpGbb, OpGbh, OpGb: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/permute_core.sv
// Combinational quadword shift/rotate/gather datapath.
// Ports:
//   op     - instruction opcode
//   ra, rb - source operands; vector index WIDTH-1 is architectural bit 0
//   I7     - immediate; index 6 is architectural bit 0
//   result - permuted value (zero for non-permute opcodes)
//   legal  - op belongs to the permute group
module permute_core import permute_pipe_pkg::*; #(
  parameter int unsigned WIDTH = 128
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic [6:0]       I7,
  output logic [WIDTH-1:0] result,
  output logic             legal
);

  localparam int unsigned Bytes = WIDTH / 8;
  localparam int unsigned Nb    = $clog2(Bytes);

  // Preferred word rb[0:31]; pw[k] is architectural bit 31-k, so counts are right-aligned.
  logic [31:0] pw;
  logic [31:0] gather;
  logic        unused_ops;

  assign pw         = rb[WIDTH-1 -: 32];
  assign unused_ops = ^{rb, I7};

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned n);
    // n == 0 makes the right shift WIDTH wide, which yields zero.
    return (v << n) | (v >> (WIDTH - n));
  endfunction

  // Byte shift with an Nb+1 bit count; the top bit set means count >= Bytes.
  function automatic logic [WIDTH-1:0] shl_bytes(input logic [WIDTH-1:0] v,
                                                 input logic [Nb:0]      n);
    return n[Nb] ? '0 : v << {n[Nb-1:0], 3'b000};
  endfunction

  always_comb begin
    result = '0;
    gather = '0;
    legal  = is_permute_op(op);
    case (op)
      OpShlqbi:   result = ra << pw[2:0];
      OpShlqbii:  result = ra << I7[2:0];
      OpShlqby:   result = shl_bytes(ra, pw[Nb:0]);
      OpShlqbyi:  result = shl_bytes(ra, I7[Nb:0]);
      OpShlqbybi: result = shl_bytes(ra, pw[Nb+3:3]);
      OpRotqby:   result = rotl(ra, 32'({pw[Nb-1:0], 3'b000}));
      OpRotqbyi:  result = rotl(ra, 32'({I7[Nb-1:0], 3'b000}));
      OpRotqbybi: result = rotl(ra, 32'({pw[Nb+2:3], 3'b000}));
      OpRotqbi:   result = rotl(ra, 32'(pw[2:0]));
      OpRotqbii:  result = rotl(ra, 32'(I7[2:0]));
      // Gathered bit j comes from the element j places from the right; last element
      // lands on word-0 bit 31.
      OpGbb: begin
        for (int unsigned j = 0; j < Bytes; j++) gather[j] = ra[8*j];
        result = {gather, {(WIDTH-32){1'b0}}};
      end
      OpGbh: begin
        for (int unsigned j = 0; j < WIDTH / 16; j++) gather[j] = ra[16*j];
        result = {gather, {(WIDTH-32){1'b0}}};
      end
      OpGb: begin
        for (int unsigned j = 0; j < WIDTH / 32; j++) gather[j] = ra[32*j];
        result = {gather, {(WIDTH-32){1'b0}}};
      end
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/permute_pipe.sv
// Pipelined odd-pipe permute unit with per-stage forwarding taps.
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   in_valid, op, ra, rb - issue strobe, opcode, source operands
//   I7, rt_address       - immediate, destination register
//   stall, flush         - hold all stages / kill all in-flight results
//   out_valid, out_rt_address, out_data - final-stage result
//   fw_stage             - tap 1 in the most significant TapBits, tap LATENCY least
//   illegal_op           - one-cycle pulse after a non-permute issue
// Vector index WIDTH-1 (resp. 6) is architectural bit 0 throughout.
module permute_pipe import permute_pipe_pkg::*; #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned LATENCY = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  opcode_t                       op,
  input  logic [WIDTH-1:0]              ra,
  input  logic [WIDTH-1:0]              rb,
  input  logic [6:0]                    I7,
  input  logic [6:0]                    rt_address,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [6:0]                    out_rt_address,
  output logic [WIDTH-1:0]              out_data,
  output logic [LATENCY*(WIDTH+8)-1:0]  fw_stage,
  output logic                          illegal_op
);

  localparam int unsigned TapBits = fw_tap_bits(WIDTH);

  typedef struct packed {
    logic             valid;
    logic [6:0]       rt_address;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           stage_q [LATENCY];
  stage_t           stage_d [LATENCY];
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] result;
  logic             legal;

  permute_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (op),
    .ra     (ra),
    .rb     (rb),
    .I7     (I7),
    .result (result),
    .legal  (legal)
  );

  always_comb begin
    stage_d   = stage_q;
    illegal_d = 1'b0;
    if (flush) begin
      // Only valids are killed; stale data/address are harmless once unqualified.
      for (int unsigned i = 0; i < LATENCY; i++) stage_d[i].valid = 1'b0;
    end else if (!stall) begin
      stage_d[0] = '{valid: in_valid & legal, rt_address: rt_address, data: result};
      for (int unsigned i = 1; i < LATENCY; i++) stage_d[i] = stage_q[i-1];
      illegal_d = in_valid & ~legal;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) stage_q[i] <= '0;
      illegal_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < LATENCY; i++) stage_q[i] <= stage_d[i];
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    fw_stage = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      fw_stage[(LATENCY-1-i)*TapBits +: TapBits] = stage_q[i];
    end
  end

  assign out_valid      = stage_q[LATENCY-1].valid;
  assign out_rt_address = stage_q[LATENCY-1].rt_address;
  assign out_data       = stage_q[LATENCY-1].data;
  assign illegal_op     = illegal_q;

endmodule
